rgb_value_bcd: RTL and testbench
================================

Name: rgb_value_bcd

Overview:
- Converts three binary colour-channel values (R, G, B) into hundreds/tens/units BCD digits using an iterative shift-add-3 (double-dabble) engine, with all three channels processed in parallel.
- Sits directly upstream of the per-digit glyph ROM stage: each registered digit selects which digit glyph ROM's row data is shown for that channel/position on the VGA value display.
- Start/busy/done handshake; digit outputs hold their last converted value between conversions.

Parameters:
- IN_W, 8, channel input width; legal 4..9 (max 511 fits three BCD digits); number of SHIFT cycles = IN_W.
- BLANK_LZ, 0, 1 = leading-zero blanking: blanked digit positions output 4'hA (blank glyph code).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request conversion; sampled only in IDLE
- val_r  in  IN_W  red channel value
- val_g  in  IN_W  green channel value
- val_b  in  IN_W  blue channel value
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: new digits valid
- dig_r_h, dig_r_d, dig_r_u  out  4 each  red hundreds/tens/units
- dig_g_h, dig_g_d, dig_g_u  out  4 each  green digits
- dig_b_h, dig_b_d, dig_b_u  out  4 each  blue digits

Behaviour:
- Interface clocking: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, all nine digit outputs=4'h0 (also when BLANK_LZ=1), internal shift registers and counter cleared.
- States: IDLE, SHIFT.
- IDLE with start=1 at edge k:
  - capture val_r/g/b into shift registers and clear the BCD scratch fields.
  - cnt=0, busy=1 after edge k; go to SHIFT.
- SHIFT, each edge k+1..k+IN_W, per channel:
  - add 3 to each BCD nibble that is >=5;
  - then shift {bcd, bin} left by 1;
  - cnt increments.
- Final SHIFT edge (k+IN_W):
  - write digit outputs from the adjusted result;
  - done=1 for exactly one cycle;
  - busy=0; return to IDLE.
- Latency: start accepted at edge k -> digits and done visible after edge k+IN_W (8 cycles at default).
- Back-to-back: start=1 while done=1 is accepted (state is IDLE), giving a throughput of one conversion per IN_W+1 cycles.
- start while busy=1 is ignored. No queuing and no error flag.
- Inputs are sampled only at the accepting edge; changes during SHIFT do not affect the result.
- Digit outputs change only on the done edge. They are stable otherwise, including during SHIFT.
- BLANK_LZ=1, applied at output-write time:
  - h==0 -> h out = 4'hA;
  - h==0 and d==0 -> d out = 4'hA too;
  - u is never blanked (value 0 -> A,A,0).
- Reset asserted mid-conversion:
  - immediate return to the reset values;
  - no done pulse;
  - partial result discarded.
- done and busy are never both 1.

Optional Feature:
- Macro: RGB_VALUE_BCD_AUTO_EN.
- Defined:
  - block holds last-converted copies of val_r/g/b;
  - in IDLE, if any input differs from its copy, or a refresh is pending after reset, a conversion self-starts exactly as if start=1;
  - copies update at the accepting edge;
  - the start port remains functional (OR with the internal trigger).
- Not defined: conversions occur only on an external start; no copy registers are built.

Test Plan:
- Reset then idle 20 cycles, start=0 -> all digits 0, busy=0, done never pulses.
- val_r=255, val_g=128, val_b=0, start pulse at edge k -> busy high k+1..k+8; done at k+8 only; R=2,5,5; G=1,2,8; B=0,0,0.
- BLANK_LZ=1, values 7/40/0 -> R=A,A,7; G=A,4,0; B=A,A,0.
- Start held high continuously with values 99/100/201 -> done every 9 cycles; each result R=0,9,9; G=1,0,0; B=2,0,1. A start pulse mid-conversion is ignored.
- Change val_g to 5 during SHIFT -> result uses the value captured at the accepting edge; rst pulsed at SHIFT cycle 4 -> no done, digits back to 0.
- With RGB_VALUE_BCD_AUTO_EN and start tied 0 -> one conversion after reset; changing val_b 0->64 triggers one conversion giving B=0,6,4; inputs held steady -> no further done pulses.

Source files
------------

// File: rtl/rgb_value_bcd_if.sv
// Handshake and digit bus for rgb_value_bcd: start/busy/done, three channel
// values in, nine BCD digits out. The master side drives values and start.
interface rgb_value_bcd_if #(
  parameter int unsigned IN_W = 8
);
  logic            start;
  logic [IN_W-1:0] val_r;
  logic [IN_W-1:0] val_g;
  logic [IN_W-1:0] val_b;
  logic            busy;
  logic            done;
  logic [3:0]      dig_r_h;
  logic [3:0]      dig_r_d;
  logic [3:0]      dig_r_u;
  logic [3:0]      dig_g_h;
  logic [3:0]      dig_g_d;
  logic [3:0]      dig_g_u;
  logic [3:0]      dig_b_h;
  logic [3:0]      dig_b_d;
  logic [3:0]      dig_b_u;

  modport master (
    output start, val_r, val_g, val_b,
    input  busy, done,
    input  dig_r_h, dig_r_d, dig_r_u,
    input  dig_g_h, dig_g_d, dig_g_u,
    input  dig_b_h, dig_b_d, dig_b_u
  );

  modport slave (
    input  start, val_r, val_g, val_b,
    output busy, done,
    output dig_r_h, dig_r_d, dig_r_u,
    output dig_g_h, dig_g_d, dig_g_u,
    output dig_b_h, dig_b_d, dig_b_u
  );
endinterface

// File: rtl/rgb_value_bcd.sv
// rgb_value_bcd: iterative double-dabble conversion of three colour channel
// values into hundreds/tens/units BCD digits for the glyph ROM stage.
// All three channels shift in parallel; one conversion takes IN_W cycles.
// Optional macro RGB_VALUE_BCD_AUTO_EN: self-start whenever an input differs
// from the last converted value, and once after reset.
module rgb_value_bcd #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic           clk,
  input  logic           rst,
  rgb_value_bcd_if.slave bus
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned SR_W  = BCD_W + IN_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state;
  logic [SR_W-1:0]    sr_r;
  logic [SR_W-1:0]    sr_g;
  logic [SR_W-1:0]    sr_b;
  logic [SR_W-1:0]    nxt_r;
  logic [SR_W-1:0]    nxt_g;
  logic [SR_W-1:0]    nxt_b;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   out_r;
  logic [BCD_W-1:0]   out_g;
  logic [BCD_W-1:0]   out_b;
  logic               trig;
  logic               last_step;

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[IN_W + 4*i +: 4] >= 4'd5) begin
        t[IN_W + 4*i +: 4] = t[IN_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Leading-zero blanking: hundreds, then tens, replaced by the blank glyph.
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] o;
    o = bcd;
    if ((BLANK_LZ != 0) && (bcd[11:8] == 4'd0)) begin
      o[11:8] = 4'hA;
      if (bcd[7:4] == 4'd0) begin
        o[7:4] = 4'hA;
      end
    end
    return o;
  endfunction

  // Next shift-register contents for every channel.
  always_comb begin
    nxt_r = dd_step(sr_r);
    nxt_g = dd_step(sr_g);
    nxt_b = dd_step(sr_b);
  end

  assign last_step = (cnt == CNT_W'(IN_W - 1));

`ifdef RGB_VALUE_BCD_AUTO_EN
  logic [IN_W-1:0] last_r;
  logic [IN_W-1:0] last_g;
  logic [IN_W-1:0] last_b;
  logic            refresh_pend;

  // Conversion trigger: external start, pending post-reset refresh, or input change.
  assign trig = bus.start | refresh_pend |
                (bus.val_r != last_r) | (bus.val_g != last_g) | (bus.val_b != last_b);

  // Copies of the values last accepted for conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r       <= '0;
      last_g       <= '0;
      last_b       <= '0;
      refresh_pend <= 1'b1;
    end else if ((state == IDLE) && trig) begin
      last_r       <= bus.val_r;
      last_g       <= bus.val_g;
      last_b       <= bus.val_b;
      refresh_pend <= 1'b0;
    end
  end
`else
  // Conversion trigger: external start only.
  assign trig = bus.start;
`endif

  // Conversion FSM with shift registers, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sr_r   <= '0;
      sr_g   <= '0;
      sr_b   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            sr_r   <= {BCD_W'(0), bus.val_r};
            sr_g   <= {BCD_W'(0), bus.val_g};
            sr_b   <= {BCD_W'(0), bus.val_b};
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sr_r <= nxt_r;
          sr_g <= nxt_g;
          sr_b <= nxt_b;
          cnt  <= cnt + CNT_W'(1);
          if (last_step) begin
            out_r  <= blank_lz(nxt_r[SR_W-1 -: BCD_W]);
            out_g  <= blank_lz(nxt_g[SR_W-1 -: BCD_W]);
            out_b  <= blank_lz(nxt_b[SR_W-1 -: BCD_W]);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.dig_r_h = out_r[11:8];
  assign bus.dig_r_d = out_r[7:4];
  assign bus.dig_r_u = out_r[3:0];
  assign bus.dig_g_h = out_g[11:8];
  assign bus.dig_g_d = out_g[7:4];
  assign bus.dig_g_u = out_g[3:0];
  assign bus.dig_b_h = out_b[11:8];
  assign bus.dig_b_d = out_b[7:4];
  assign bus.dig_b_u = out_b[3:0];

endmodule

// File: tb/tb_rgb_value_bcd.sv
// Bench for rgb_value_bcd: one instance without and one with leading-zero
// blanking, driven with identical stimulus.
module tb_rgb_value_bcd;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cyc;

  rgb_value_bcd_if #(.IN_W(8)) if0 ();
  rgb_value_bcd_if #(.IN_W(8)) if1 ();

  rgb_value_bcd #(.IN_W(8), .BLANK_LZ(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  rgb_value_bcd #(.IN_W(8), .BLANK_LZ(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [11:0] er;
    logic [11:0] eg;
    logic [11:0] eb;
    logic [11:0] br;
    logic [11:0] bg;
    logic [11:0] bb;
  } vec_t;

  vec_t vecs[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // done and busy must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ((if0.done && if0.busy) || (if1.done && if1.busy)) begin
        n_err++;
        $display("FAIL done_busy_excl: got done=%0d busy=%0d, required not both 1", if0.done, if0.busy);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if0.val_r = r; if0.val_g = g; if0.val_b = b;
    if1.val_r = r; if1.val_g = g; if1.val_b = b;
  endtask

  task automatic set_start(input logic s);
    if0.start = s;
    if1.start = s;
  endtask

  task automatic check_digits(input string nm, input logic [11:0] er, input logic [11:0] eg,
                              input logic [11:0] eb, input logic [11:0] br,
                              input logic [11:0] bg, input logic [11:0] bb);
    check({nm, "_r"},  int'({if0.dig_r_h, if0.dig_r_d, if0.dig_r_u}), int'(er));
    check({nm, "_g"},  int'({if0.dig_g_h, if0.dig_g_d, if0.dig_g_u}), int'(eg));
    check({nm, "_b"},  int'({if0.dig_b_h, if0.dig_b_d, if0.dig_b_u}), int'(eb));
    check({nm, "_br"}, int'({if1.dig_r_h, if1.dig_r_d, if1.dig_r_u}), int'(br));
    check({nm, "_bg"}, int'({if1.dig_g_h, if1.dig_g_d, if1.dig_g_u}), int'(bg));
    check({nm, "_bb"}, int'({if1.dig_b_h, if1.dig_b_d, if1.dig_b_u}), int'(bb));
  endtask

  // Wait (bounded) for done; returns cycles waited.
  task automatic wait_done(output int w);
    w = 0;
    while (!if0.done && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", int'(if0.done), 1);
  endtask

  // Count done pulses over n idle cycles.
  task automatic idle_count(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (if0.done || if1.done) dones++;
    end
  endtask

  // Start pulse, then measure latency, busy length and done width.
  task automatic run_conv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int lat;
    int bcnt;
    @(negedge clk);
    set_in(r, g, b);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    lat  = 0;
    bcnt = 0;
    while (!if0.done && lat < 20) begin
      if (if0.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 8);
    check("busy_len", bcnt, 8);
    check("done_dut1", int'(if1.done), 1);
  endtask

  initial begin
    int d;
    int w;
    int stamp[3];
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    set_start(1'b0);
    set_in(8'd0, 8'd0, 8'd0);

    vecs[0] = '{8'd255, 8'd128, 8'd0,   12'h255, 12'h128, 12'h000, 12'h255, 12'h128, 12'hAA0};
    vecs[1] = '{8'd7,   8'd40,  8'd0,   12'h007, 12'h040, 12'h000, 12'hAA7, 12'hA40, 12'hAA0};
    vecs[2] = '{8'd99,  8'd100, 8'd201, 12'h099, 12'h100, 12'h201, 12'hA99, 12'h100, 12'h201};
    vecs[3] = '{8'd10,  8'd5,   8'd250, 12'h010, 12'h005, 12'h250, 12'hA10, 12'hAA5, 12'h250};

    repeat (3) @(negedge clk);
    rst = 1'b0;

`ifdef RGB_VALUE_BCD_AUTO_EN
    // Self-start once after reset, then only on an input change.
    wait_done(w);
    check_digits("auto_rst", 12'h000, 12'h000, 12'h000, 12'hAA0, 12'hAA0, 12'hAA0);
    idle_count(20, d);
    check("auto_quiet1", d, 0);
    set_in(8'd0, 8'd0, 8'd64);
    wait_done(w);
    check_digits("auto_b64", 12'h000, 12'h000, 12'h064, 12'hAA0, 12'hAA0, 12'hA64);
    idle_count(20, d);
    check("auto_quiet2", d, 0);
`else
    // Reset state held across 20 idle cycles.
    idle_count(20, d);
    check("idle_done", d, 0);
    check("idle_busy", int'(if0.busy), 0);
    check_digits("reset", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);

    // Table of single conversions.
    for (int i = 0; i < 4; i++) begin
      run_conv(vecs[i].r, vecs[i].g, vecs[i].b);
      check_digits($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb,
                   vecs[i].br, vecs[i].bg, vecs[i].bb);
      @(negedge clk);
      check("done_width", int'(if0.done), 0);
      check("digits_hold", int'({if0.dig_r_h, if0.dig_r_d, if0.dig_r_u}), int'(vecs[i].er));
    end

    // Input change and extra start pulse during SHIFT are ignored.
    @(negedge clk);
    set_in(8'd7, 8'd40, 8'd0);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (3) @(negedge clk);
    if0.val_g = 8'd5;
    if1.val_g = 8'd5;
    set_start(1'b1);
    check("digits_stable_shift", int'({if0.dig_g_h, if0.dig_g_d, if0.dig_g_u}), 12'h005);
    @(negedge clk);
    set_start(1'b0);
    wait_done(w);
    check("midchange_wait", w, 4);
    check_digits("midchange", 12'h007, 12'h040, 12'h000, 12'hAA7, 12'hA40, 12'hAA0);
    @(negedge clk);
    check("no_requeue", int'(if0.busy), 0);

    // Start held high: back-to-back conversions every 9 cycles.
    set_in(8'd99, 8'd100, 8'd201);
    set_start(1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      wait_done(w);
      stamp[n] = cyc;
      check_digits("b2b", 12'h099, 12'h100, 12'h201, 12'hA99, 12'h100, 12'h201);
      if (n == 2) set_start(1'b0);
    end
    check("b2b_period1", stamp[1] - stamp[0], 9);
    check("b2b_period2", stamp[2] - stamp[1], 9);
    @(negedge clk);
    check("b2b_stop", int'(if0.busy), 0);

    // Reset during SHIFT: no done, digits back to zero.
    @(negedge clk);
    set_in(8'd255, 8'd128, 8'd0);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", int'(if0.busy), 0);
    check_digits("rst_mid", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    idle_count(15, d);
    check("rst_no_done", d, 0);
    check_digits("rst_after", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
